// File: rtl/vga_timing_generator.sv
// Free-running VGA raster timing: scan position, display enable, sync pulses and line/frame strobes.
// Optional frame counter output enabled by defining VGA_FRAME_COUNT_EN.
module vga_timing_generator #(
  parameter int H_VISIBLE       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic               vga_clock,
  input  logic               reset,
  output logic               h_sync,
  output logic               v_sync,
  output logic               display_enable,
  output logic signed [31:0] column,
  output logic signed [31:0] row,
  output logic               line_start,
  output logic               frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0]        frame_count
`endif
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam logic        SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic        SYNC_OFF = ~SYNC_ON;

  if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_params
    $error("vga_timing_generator: porch and sync widths must all be >= 1");
  end

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  phase_e        h_ph_q, h_ph_d;
  phase_e        v_ph_q, v_ph_d;
  logic          h_wrap, v_wrap;

  logic [HW-1:0] column_q;
  logic [VW-1:0] row_q;
  logic          de_q, de_d;
  logic          h_sync_q, h_sync_d;
  logic          v_sync_q, v_sync_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  always_comb begin
    // ">=" keeps a corrupted count from running past the total
    h_wrap  = (h_cnt_q >= HW'(H_TOTAL - 1));
    v_wrap  = (v_cnt_q >= VW'(V_TOTAL - 1));
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    h_ph_d  = h_ph_q;
    v_cnt_d = v_cnt_q;
    v_ph_d  = v_ph_q;

    case (h_ph_q)
      PH_ACTIVE: if (h_cnt_q == HW'(H_VISIBLE - 1))                   h_ph_d = PH_FRONT;
      PH_FRONT:  if (h_cnt_q == HW'(H_VISIBLE + H_FRONT - 1))          h_ph_d = PH_SYNC;
      PH_SYNC:   if (h_cnt_q == HW'(H_VISIBLE + H_FRONT + H_SYNC - 1)) h_ph_d = PH_BACK;
      PH_BACK:   if (h_wrap)                                           h_ph_d = PH_ACTIVE;
      default:                                                         h_ph_d = PH_BACK;
    endcase

    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
      case (v_ph_q)
        PH_ACTIVE: if (v_cnt_q == VW'(V_VISIBLE - 1))                   v_ph_d = PH_FRONT;
        PH_FRONT:  if (v_cnt_q == VW'(V_VISIBLE + V_FRONT - 1))          v_ph_d = PH_SYNC;
        PH_SYNC:   if (v_cnt_q == VW'(V_VISIBLE + V_FRONT + V_SYNC - 1)) v_ph_d = PH_BACK;
        PH_BACK:   if (v_wrap)                                           v_ph_d = PH_ACTIVE;
        default:                                                         v_ph_d = PH_BACK;
      endcase
    end

    // Outputs are registered from next-state values so they align with column/row
    de_d          = (h_ph_d == PH_ACTIVE) && (v_ph_d == PH_ACTIVE);
    h_sync_d      = (h_ph_d == PH_SYNC) ? SYNC_ON : SYNC_OFF;
    v_sync_d      = (v_ph_d == PH_SYNC) ? SYNC_ON : SYNC_OFF;
    line_start_d  = (h_cnt_d == '0);
    frame_start_d = line_start_d && (v_cnt_d == '0);
  end

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      h_cnt_q       <= HW'(H_TOTAL - 1);
      v_cnt_q       <= VW'(V_TOTAL - 1);
      h_ph_q        <= PH_BACK;
      v_ph_q        <= PH_BACK;
      column_q      <= '0;
      row_q         <= '0;
      de_q          <= 1'b0;
      h_sync_q      <= SYNC_OFF;
      v_sync_q      <= SYNC_OFF;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_ph_q        <= h_ph_d;
      v_ph_q        <= v_ph_d;
      column_q      <= h_cnt_d;
      row_q         <= v_cnt_d;
      de_q          <= de_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign column         = 32'(column_q);
  assign row            = 32'(row_q);
  assign display_enable = de_q;
  assign h_sync         = h_sync_q;
  assign v_sync         = v_sync_q;
  assign line_start     = line_start_q;
  assign frame_start    = frame_start_q;

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  always_comb begin
    frame_count_d = frame_start_d ? frame_count_q + 16'd1 : frame_count_q;
  end

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) frame_count_q <= '0;
    else        frame_count_q <= frame_count_d;
  end

  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench: default-size generator for line-level timing, small generator for frame-level and reset timing.
module tb_vga_timing_generator;

  localparam int B_HV = 8, B_HF = 2, B_HS = 3, B_HB = 2;
  localparam int B_VV = 6, B_VF = 2, B_VS = 2, B_VB = 3;
  localparam int B_HT = B_HV + B_HF + B_HS + B_HB;  // 15
  localparam int B_VT = B_VV + B_VF + B_VS + B_VB;  // 13

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic a_hs, a_vs, a_de, a_ls, a_fs;
  logic b_hs, b_vs, b_de, b_ls, b_fs;
  logic signed [31:0] a_col, a_row, b_col, b_row;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] a_fc, b_fc;
`endif

  vga_timing_generator u_dut_a (
    .vga_clock(clk), .reset(rst_a), .h_sync(a_hs), .v_sync(a_vs),
    .display_enable(a_de), .column(a_col), .row(a_row),
    .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(a_fc)
`endif
  );

  vga_timing_generator #(
    .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
    .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
    .SYNC_ACTIVE_LOW(0)
  ) u_dut_b (
    .vga_clock(clk), .reset(rst_b), .h_sync(b_hs), .v_sync(b_vs),
    .display_enable(b_de), .column(b_col), .row(b_row),
    .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(b_fc)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  int  ha, va, hb, vb, cyc;
  bit  a_run, b_run;
  int  last_ls_a, last_fs_b, hs_low_a, hs_first_a, fc_b;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_pos(input string n, input bit run, input int h, input int v,
                           input int hv, input int hf, input int hs, input int vv,
                           input int vf, input int vs, input bit sal,
                           input logic signed [31:0] col, input logic signed [31:0] rw,
                           input logic de, input logic hsy, input logic vsy,
                           input logic ls, input logic fs);
    bit h_act, v_act;
    if (!run) begin
      check({n, "_rst_col"}, col, 0);
      check({n, "_rst_row"}, rw, 0);
      check({n, "_rst_de"}, 32'(de), 0);
      check({n, "_rst_ls"}, 32'(ls), 0);
      check({n, "_rst_fs"}, 32'(fs), 0);
      check({n, "_rst_hs"}, 32'(hsy), 32'(sal));
      check({n, "_rst_vs"}, 32'(vsy), 32'(sal));
    end else begin
      h_act = (h >= hv + hf) && (h < hv + hf + hs);
      v_act = (v >= vv + vf) && (v < vv + vf + vs);
      check({n, "_col"}, col, h);
      check({n, "_row"}, rw, v);
      check({n, "_de"}, 32'(de), 32'((h < hv) && (v < vv)));
      check({n, "_hs"}, 32'(hsy), 32'(h_act ? !sal : sal));
      check({n, "_vs"}, 32'(vsy), 32'(v_act ? !sal : sal));
      check({n, "_ls"}, 32'(ls), 32'(h == 0));
      check({n, "_fs"}, 32'(fs), 32'((h == 0) && (v == 0)));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (a_run) begin
      ha = (ha == 799) ? 0 : ha + 1;
      if (ha == 0) va = (va == 524) ? 0 : va + 1;
    end
    if (b_run) begin
      hb = (hb == B_HT - 1) ? 0 : hb + 1;
      if (hb == 0) vb = (vb == B_VT - 1) ? 0 : vb + 1;
      if (hb == 0 && vb == 0) fc_b = (fc_b + 1) % 65536;
    end
    @(negedge clk);
    check_pos("a", a_run, ha, va, 640, 16, 96, 480, 10, 2, 1'b1,
              a_col, a_row, a_de, a_hs, a_vs, a_ls, a_fs);
    check_pos("b", b_run, hb, vb, B_HV, B_HF, B_HS, B_VV, B_VF, B_VS, 1'b0,
              b_col, b_row, b_de, b_hs, b_vs, b_ls, b_fs);
`ifdef VGA_FRAME_COUNT_EN
    check("b_fc", 32'(b_fc), fc_b);
`endif
    if (a_run && a_ls === 1'b1) begin
      if (last_ls_a >= 0) check("a_ls_period", cyc - last_ls_a, 800);
      last_ls_a = cyc;
    end
    if (b_run && b_fs === 1'b1) begin
      if (last_fs_b >= 0) check("b_fs_period", cyc - last_fs_b, B_HT * B_VT);
      last_fs_b = cyc;
    end
    if (a_run && va == 0 && a_hs === 1'b0) begin
      if (hs_low_a == 0) hs_first_a = a_col;
      hs_low_a++;
    end
  endtask

  initial begin
    bit reached;
    cyc = 0; a_run = 0; b_run = 0;
    ha = 799; va = 524; hb = B_HT - 1; vb = B_VT - 1;
    last_ls_a = -1; last_fs_b = -1; hs_low_a = 0; hs_first_a = -1; fc_b = 0;
    rst_a = 1'b0; rst_b = 1'b0;

    repeat (5) tick();

    rst_a = 1'b1; rst_b = 1'b1;
    a_run = 1; b_run = 1;
    tick();
    check("first_a_col", a_col, 0);
    check("first_a_fs", 32'(a_fs), 1);
`ifdef VGA_FRAME_COUNT_EN
    check("first_b_fc", 32'(b_fc), 1);
`endif

    repeat (1700) tick();
    check("a_hs_low_cycles", hs_low_a, 96);
    check("a_hs_first_col", hs_first_a, 656);

    reached = 0;
    for (int i = 0; i < 300; i++) begin
      if (hb == 6 && vb == 4) begin
        reached = 1;
        break;
      end
      tick();
    end
    check("b_reach_mid", 32'(reached), 1);
    check("b_mid_de", 32'(b_de), 1);

    #1 rst_b = 1'b0;
    #1;
    b_run = 0;
    check_pos("b_async", 1'b0, 0, 0, B_HV, B_HF, B_HS, B_VV, B_VF, B_VS, 1'b0,
              b_col, b_row, b_de, b_hs, b_vs, b_ls, b_fs);
    hb = B_HT - 1; vb = B_VT - 1; fc_b = 0; last_fs_b = -1;
    repeat (2) tick();

    rst_b = 1'b1;
    b_run = 1;
    tick();
    check("b_restart_col", b_col, 0);
    check("b_restart_row", b_row, 0);
    check("b_restart_fs", 32'(b_fs), 1);

    repeat (420) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
